// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI port among N_REQ debug requesters.
// One transaction at a time; a watchdog fabricates a failure response if the debug module goes silent.
module dmi_arbiter #(
    parameter int N_REQ    = 2,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_BITS = 16,
    localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      in_req_valid,
    output logic [N_REQ-1:0]      in_req_ready,
    input  logic [7*N_REQ-1:0]    in_req_bits_addr,
    input  logic [2*N_REQ-1:0]    in_req_bits_op,
    input  logic [32*N_REQ-1:0]   in_req_bits_data,
    output logic [N_REQ-1:0]      in_resp_valid,
    input  logic [N_REQ-1:0]      in_resp_ready,
    output logic [1:0]            in_resp_bits_resp,
    output logic [31:0]           in_resp_bits_data,
    output logic                  out_req_valid,
    input  logic                  out_req_ready,
    output logic [6:0]            out_req_bits_addr,
    output logic [1:0]            out_req_bits_op,
    output logic [31:0]           out_req_bits_data,
    input  logic                  out_resp_valid,
    output logic                  out_resp_ready,
    input  logic [1:0]            out_resp_bits_resp,
    input  logic [31:0]           out_resp_bits_data,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  timeout_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

    state_t              state, state_nx;
    logic [OW-1:0]       last_grant;
    logic [OW-1:0]       winner, win_hi, win_lo;
    logic                found_hi;
    logic                drop_pending;
    logic [CNT_BITS-1:0] counter;
    logic                grant_en, resp_hs, timeout_hit, drop_sink, own_resp_ready;
    logic [N_REQ-1:0]    owner_onehot;
    logic [6:0]          sel_addr;
    logic [1:0]          sel_op;
    logic [31:0]         sel_data;

    // Indices above last_grant take priority; otherwise wrap to the lowest valid index.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in_req_valid[i]) begin
                if (i > int'(last_grant)) begin
                    win_hi   = OW'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo = OW'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        sel_addr       = '0;
        sel_op         = '0;
        sel_data       = '0;
        owner_onehot   = '0;
        own_resp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (OW'(i) == winner) begin
                sel_addr = in_req_bits_addr[7*i +: 7];
                sel_op   = in_req_bits_op[2*i +: 2];
                sel_data = in_req_bits_data[32*i +: 32];
            end
            if (OW'(i) == owner) begin
                owner_onehot[i] = 1'b1;
                own_resp_ready  = in_resp_ready[i];
            end
        end
    end

    assign grant_en    = !reset && (state == S_IDLE) && !drop_pending && (|in_req_valid);
    assign resp_hs     = ((state == S_WAIT) && out_resp_valid && own_resp_ready) ||
                         ((state == S_FAULT) && own_resp_ready);
    assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && !resp_hs &&
                         (counter == CNT_BITS'(TIMEOUT - 1));
    assign drop_sink   = drop_pending && out_resp_valid &&
                         ((state == S_IDLE) || (state == S_FAULT));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (grant_en)      state_nx = S_ISSUE;
            S_ISSUE: if (out_req_ready) state_nx = S_WAIT;
            S_WAIT: begin
                if (resp_hs)          state_nx = S_IDLE;
                else if (timeout_hit) state_nx = S_FAULT;
            end
            S_FAULT: if (resp_hs)       state_nx = S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner             <= '0;
            last_grant        <= OW'(N_REQ - 1);
            drop_pending      <= 1'b0;
            counter           <= '0;
            out_req_bits_addr <= '0;
            out_req_bits_op   <= '0;
            out_req_bits_data <= '0;
        end else begin
            if (grant_en) begin
                owner             <= winner;
                out_req_bits_addr <= sel_addr;
                out_req_bits_op   <= sel_op;
                out_req_bits_data <= sel_data;
            end
            if ((state == S_ISSUE) && out_req_ready) counter <= '0;
            else if (state == S_WAIT)                counter <= counter + 1'b1;
            if (resp_hs) last_grant <= owner;
            if (timeout_hit)    drop_pending <= 1'b1;
            else if (drop_sink) drop_pending <= 1'b0;
        end
    end

    always_comb begin
        in_req_ready      = grant_en ? (N_REQ'(1) << winner) : '0;
        in_resp_valid     = '0;
        in_resp_bits_resp = out_resp_bits_resp;
        in_resp_bits_data = out_resp_bits_data;
        out_req_valid     = 1'b0;
        out_resp_ready    = 1'b0;
        busy              = (state != S_IDLE);
        timeout_pulse     = timeout_hit;
        case (state)
            S_IDLE:  out_resp_ready = drop_pending;
            S_ISSUE: out_req_valid  = 1'b1;
            S_WAIT: begin
                in_resp_valid  = out_resp_valid ? owner_onehot : '0;
                out_resp_ready = own_resp_ready;
            end
            S_FAULT: begin
                in_resp_valid     = owner_onehot;
                in_resp_bits_resp = 2'd2;
                in_resp_bits_data = '0;
                out_resp_ready    = drop_pending;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: single transaction, round-robin, backpressure,
// watchdog fault with late-response drop, mid-transaction reset and handshake-at-timeout.
module tb_dmi_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;
    localparam int CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_ready;
    logic [13:0]   req_addr;
    logic [3:0]    req_op;
    logic [63:0]   req_data;
    logic [N-1:0]  resp_valid, resp_ready;
    logic [1:0]    resp_resp;
    logic [31:0]   resp_data;
    logic          o_req_valid, o_req_ready;
    logic [6:0]    o_req_addr;
    logic [1:0]    o_req_op;
    logic [31:0]   o_req_data;
    logic          o_resp_valid, o_resp_ready;
    logic [1:0]    o_resp_resp;
    logic [31:0]   o_resp_data;
    logic [0:0]    owner;
    logic          busy, timeout_pulse;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    dmi_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(req_valid), .in_req_ready(req_ready),
        .in_req_bits_addr(req_addr), .in_req_bits_op(req_op), .in_req_bits_data(req_data),
        .in_resp_valid(resp_valid), .in_resp_ready(resp_ready),
        .in_resp_bits_resp(resp_resp), .in_resp_bits_data(resp_data),
        .out_req_valid(o_req_valid), .out_req_ready(o_req_ready),
        .out_req_bits_addr(o_req_addr), .out_req_bits_op(o_req_op), .out_req_bits_data(o_req_data),
        .out_resp_valid(o_resp_valid), .out_resp_ready(o_resp_ready),
        .out_resp_bits_resp(o_resp_resp), .out_resp_bits_data(o_resp_data),
        .owner(owner), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int order [4] = '{0, 1, 0, 1};
        int g;

        reset = 1'b1; req_valid = '0; req_addr = '0; req_op = '0; req_data = '0;
        resp_ready = '0; o_req_ready = 1'b0; o_resp_valid = 1'b0;
        o_resp_resp = '0; o_resp_data = '0;
        step(); step();
        reset = 1'b0;
        settle();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_out_req_valid", o_req_valid, 0);
        check("rst_out_req_addr", o_req_addr, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_out_resp_ready", o_resp_ready, 0);
        check("rst_timeout", timeout_pulse, 0);

        // Single transaction from requester 0
        req_valid = 2'b01; req_addr = {7'h00, 7'h10}; req_op = {2'd0, 2'd2};
        req_data = {32'h0, 32'hDEADBEEF};
        settle();
        check("t1_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        settle();
        check("t1_out_req_valid", o_req_valid, 1);
        check("t1_out_req_addr", o_req_addr, 7'h10);
        check("t1_out_req_op", o_req_op, 2'd2);
        check("t1_out_req_data", o_req_data, 32'hDEADBEEF);
        check("t1_busy", busy, 1);
        o_req_ready = 1'b1;
        step();
        o_req_ready = 1'b0; o_resp_valid = 1'b1; o_resp_resp = 2'd0;
        o_resp_data = 32'h12345678; resp_ready = 2'b01;
        settle();
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_resp", resp_resp, 2'd0);
        check("t1_resp_data", resp_data, 32'h12345678);
        check("t1_out_resp_ready", o_resp_ready, 1);
        step();
        o_resp_valid = 1'b0; resp_ready = '0;
        settle();
        check("t1_idle", busy, 0);
        check("t1_resp_valid_off", resp_valid, 0);

        // Round-robin with both requesters valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 2'b11; req_addr = {7'h42, 7'h21}; req_op = {2'd1, 2'd2};
        req_data = {32'hB1B1B1B1, 32'hA0A0A0A0}; resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = order[k];
            settle();
            check("rr_req_ready", req_ready, (g == 0) ? 2'b01 : 2'b10);
            step();
            settle();
            check("rr_owner", owner, g);
            check("rr_addr", o_req_addr, (g == 0) ? 7'h21 : 7'h42);
            check("rr_no_ready_in_issue", req_ready, 0);
            o_req_ready = 1'b1;
            step();
            o_req_ready = 1'b0; o_resp_valid = 1'b1; o_resp_data = 32'h100 + k;
            settle();
            check("rr_resp_valid", resp_valid, (g == 0) ? 2'b01 : 2'b10);
            step();
            o_resp_valid = 1'b0;
        end
        req_valid = '0; resp_ready = '0;

        // Backpressure on request and response sides, requester 1
        req_valid = 2'b10;
        settle();
        check("bp_req_ready", req_ready, 2'b10);
        step();
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("bp_addr_stable", o_req_addr, 7'h42);
            check("bp_data_stable", o_req_data, 32'hB1B1B1B1);
            check("bp_req_valid", o_req_valid, 1);
            check("bp_busy", busy, 1);
            step();
        end
        o_req_ready = 1'b1;
        step();
        o_req_ready = 1'b0; o_resp_valid = 1'b1; o_resp_resp = 2'd1;
        o_resp_data = 32'hA5A5A5A5; resp_ready = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp_resp_held", resp_valid, 2'b10);
            check("bp_out_resp_ready", o_resp_ready, 0);
            check("bp_resp_code", resp_resp, 2'd1);
            step();
        end
        resp_ready = 2'b10;
        settle();
        check("bp_out_resp_ready_on", o_resp_ready, 1);
        check("bp_resp_data", resp_data, 32'hA5A5A5A5);
        step();
        o_resp_valid = 1'b0; resp_ready = '0;
        settle();
        check("bp_idle", busy, 0);

        // Watchdog: slave stays silent, requester 0 owns the port
        req_valid = 2'b01;
        settle();
        check("to_req_ready", req_ready, 2'b01);
        step();
        req_valid = '0; o_req_ready = 1'b1;
        step();
        o_req_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            settle();
            check("to_pulse", timeout_pulse, (c == 8) ? 1 : 0);
            check("to_no_resp", resp_valid, 0);
            if (c < 8) step();
        end
        step();
        settle();
        check("fault_resp_valid", resp_valid, 2'b01);
        check("fault_resp_code", resp_resp, 2'd2);
        check("fault_resp_data", resp_data, 0);
        check("fault_pulse_off", timeout_pulse, 0);
        check("fault_out_resp_ready", o_resp_ready, 1);
        resp_ready = 2'b01;
        step();
        resp_ready = '0; req_valid = 2'b11;
        settle();
        check("drop_no_grant", req_ready, 0);
        check("drop_sink_ready", o_resp_ready, 1);
        check("drop_idle", busy, 0);
        step();
        settle();
        check("drop_no_grant_2", req_ready, 0);
        o_resp_valid = 1'b1; o_resp_resp = 2'd0; o_resp_data = 32'h77;
        settle();
        check("drop_not_routed", resp_valid, 0);
        step();
        o_resp_valid = 1'b0;
        settle();
        check("drop_cleared_grant", req_ready, 2'b10);

        // Reset during WAIT with requester 1 owning the port
        step();
        settle();
        check("rw_owner", owner, 1);
        o_req_ready = 1'b1;
        step();
        o_req_ready = 1'b0;
        settle();
        check("rw_busy_wait", busy, 1);
        reset = 1'b1;
        step();
        settle();
        check("rw_busy", busy, 0);
        check("rw_owner_rst", owner, 0);
        check("rw_out_req_valid", o_req_valid, 0);
        check("rw_out_req_addr", o_req_addr, 0);
        check("rw_out_req_op", o_req_op, 0);
        check("rw_out_req_data", o_req_data, 0);
        check("rw_req_ready", req_ready, 0);
        check("rw_resp_valid", resp_valid, 0);
        check("rw_out_resp_ready", o_resp_ready, 0);
        check("rw_timeout", timeout_pulse, 0);
        reset = 1'b0;
        settle();
        check("rw_first_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        settle();
        check("rw_owner_0", owner, 0);

        // Response handshake lands on the counter's last cycle
        o_req_ready = 1'b1;
        step();
        o_req_ready = 1'b0;
        for (int c = 1; c < 8; c++) begin
            settle();
            check("edge_no_pulse", timeout_pulse, 0);
            step();
        end
        o_resp_valid = 1'b1; o_resp_resp = 2'd0; o_resp_data = 32'h600DF00D; resp_ready = 2'b01;
        settle();
        check("edge_resp_valid", resp_valid, 2'b01);
        check("edge_pulse_off", timeout_pulse, 0);
        check("edge_resp_data", resp_data, 32'h600DF00D);
        check("edge_resp_code", resp_resp, 2'd0);
        step();
        o_resp_valid = 1'b0; resp_ready = '0; req_valid = 2'b10;
        settle();
        check("edge_idle", busy, 0);
        check("edge_no_drop", o_resp_ready, 0);
        check("edge_grant_ok", req_ready, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
